// File: rtl/generic_tb_rtl_chunked_dma.sv
// generic_tb_rtl_chunked_dma: chunked DMA read-transform-write accelerator
module generic_tb_rtl_chunked_dma #(
  parameter int DATA_W = 64,
  parameter logic [2:0] SIZE_ENC = 3'b011,
  parameter int CHUNK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       conf_info_reg0,
  input  logic [31:0]       conf_info_generic_tb_n,
  input  logic [31:0]       conf_info_reg2,
  input  logic              conf_done,
  output logic              dma_read_ctrl_valid,
  input  logic              dma_read_ctrl_ready,
  output logic [31:0]       dma_read_ctrl_data_index,
  output logic [31:0]       dma_read_ctrl_data_length,
  output logic [2:0]        dma_read_ctrl_data_size,
  input  logic              dma_read_chnl_valid,
  output logic              dma_read_chnl_ready,
  input  logic [DATA_W-1:0] dma_read_chnl_data,
  output logic              dma_write_ctrl_valid,
  input  logic              dma_write_ctrl_ready,
  output logic [31:0]       dma_write_ctrl_data_index,
  output logic [31:0]       dma_write_ctrl_data_length,
  output logic [2:0]        dma_write_ctrl_data_size,
  output logic              dma_write_chnl_valid,
  input  logic              dma_write_chnl_ready,
  output logic [DATA_W-1:0] dma_write_chnl_data,
  output logic              acc_done,
  output logic [31:0]       debug
);
  localparam int AW = $clog2(CHUNK);
  localparam int LW = AW + 1;
  typedef enum logic [3:0] {
    IDLE = 4'd0, CONFIG = 4'd1, RD_REQ = 4'd2, RD_DATA = 4'd3,
    WR_REQ = 4'd4, WR_DATA = 4'd5, DONE = 4'd6
  } state_t;
  state_t state_q, state_d;
  logic conf_prev_q;
  logic [1:0] mode_q, mode_d;
  logic [31:0] n_q, n_d, add_q, add_d, base_q, base_d, rem_q, rem_d;
  logic [LW-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [15:0] chunks_q, chunks_d;
  logic rd_ctrl_valid_q, rd_ctrl_valid_d, rd_chnl_ready_q, rd_chnl_ready_d;
  logic wr_ctrl_valid_q, wr_ctrl_valid_d, wr_chnl_valid_q, wr_chnl_valid_d;
  logic done_q, done_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d, xf;
  logic [DATA_W-1:0] buf_q [CHUNK];
  logic buf_we, unused_ok;
  function automatic logic [LW-1:0] chunk_len(input logic [31:0] rem);
    return (rem >= 32'(CHUNK)) ? LW'(CHUNK) : rem[LW-1:0];
  endfunction
  assign unused_ok = ^conf_info_reg0[31:2];
  assign dma_read_ctrl_valid = rd_ctrl_valid_q;
  assign dma_read_ctrl_data_index = base_q;
  assign dma_read_ctrl_data_length = 32'(len_q);
  assign dma_read_ctrl_data_size = SIZE_ENC;
  assign dma_read_chnl_ready = rd_chnl_ready_q;
  assign dma_write_ctrl_valid = wr_ctrl_valid_q;
  assign dma_write_ctrl_data_index = n_q + base_q;
  assign dma_write_ctrl_data_length = 32'(len_q);
  assign dma_write_ctrl_data_size = SIZE_ENC;
  assign dma_write_chnl_valid = wr_chnl_valid_q;
  assign dma_write_chnl_data = wr_data_q;
  assign acc_done = done_q;
  assign debug = {chunks_q, 12'd0, state_q};
  // next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    n_d = n_q;
    add_d = add_q;
    base_d = base_q;
    rem_d = rem_q;
    len_d = len_q;
    cnt_d = cnt_q;
    chunks_d = chunks_q;
    buf_we = 1'b0;
    xf = (mode_q == 2'd0) ? dma_read_chnl_data :
         (mode_q == 2'd1) ? dma_read_chnl_data + DATA_W'(1) :
         (mode_q == 2'd2) ? ~dma_read_chnl_data :
                            dma_read_chnl_data + DATA_W'(add_q);
    case (state_q)
      IDLE: if (conf_done && !conf_prev_q) begin
        state_d = CONFIG;
        mode_d = conf_info_reg0[1:0];
        n_d = conf_info_generic_tb_n;
        add_d = conf_info_reg2;
        base_d = '0;
        rem_d = conf_info_generic_tb_n;
        chunks_d = '0;
      end
      CONFIG: begin
        state_d = (n_q == '0) ? DONE : RD_REQ;
        len_d = chunk_len(rem_q);
        cnt_d = '0;
      end
      RD_REQ: if (rd_ctrl_valid_q && dma_read_ctrl_ready) state_d = RD_DATA;
      RD_DATA: if (rd_chnl_ready_q && dma_read_chnl_valid) begin
        buf_we = 1'b1;
        cnt_d = (cnt_q == len_q - LW'(1)) ? '0 : cnt_q + LW'(1);
        state_d = (cnt_q == len_q - LW'(1)) ? WR_REQ : RD_DATA;
      end
      WR_REQ: if (wr_ctrl_valid_q && dma_write_ctrl_ready) state_d = WR_DATA;
      WR_DATA: if (wr_chnl_valid_q && dma_write_chnl_ready) begin
        if (cnt_q == len_q - LW'(1)) begin
          base_d = base_q + 32'(len_q);
          rem_d = rem_q - 32'(len_q);
          chunks_d = chunks_q + 16'd1;
          cnt_d = '0;
          len_d = chunk_len(rem_d);
          state_d = (rem_d != '0) ? RD_REQ : DONE;
        end else begin
          cnt_d = cnt_q + LW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rd_ctrl_valid_d = state_d == RD_REQ;
    rd_chnl_ready_d = state_d == RD_DATA;
    wr_ctrl_valid_d = state_d == WR_REQ;
    wr_chnl_valid_d = state_d == WR_DATA;
    done_d = state_d == DONE;
    wr_data_d = buf_q[cnt_d[AW-1:0]];
  end
  // control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      conf_prev_q <= 1'b0;
      mode_q <= '0;
      n_q <= '0;
      add_q <= '0;
      base_q <= '0;
      rem_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      chunks_q <= '0;
      rd_ctrl_valid_q <= 1'b0;
      rd_chnl_ready_q <= 1'b0;
      wr_ctrl_valid_q <= 1'b0;
      wr_chnl_valid_q <= 1'b0;
      done_q <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      conf_prev_q <= conf_done;
      mode_q <= mode_d;
      n_q <= n_d;
      add_q <= add_d;
      base_q <= base_d;
      rem_q <= rem_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      chunks_q <= chunks_d;
      rd_ctrl_valid_q <= rd_ctrl_valid_d;
      rd_chnl_ready_q <= rd_chnl_ready_d;
      wr_ctrl_valid_q <= wr_ctrl_valid_d;
      wr_chnl_valid_q <= wr_chnl_valid_d;
      done_q <= done_d;
      wr_data_q <= wr_data_d;
    end
  end
  // chunk buffer, filled one transformed beat at a time
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[cnt_q[AW-1:0]] <= xf;
  end
endmodule

// File: tb/tb_generic_tb_rtl_chunked_dma.sv
// tb_generic_tb_rtl_chunked_dma: scoreboard bench with memory-slave DMA model
module tb_generic_tb_rtl_chunked_dma;
  localparam int CH = 16;
  logic clk = 0, rst = 1;
  logic [31:0] conf_info_reg0 = 0, conf_info_generic_tb_n = 0, conf_info_reg2 = 0;
  logic conf_done = 0;
  logic dma_read_ctrl_valid, dma_read_ctrl_ready = 0;
  logic [31:0] dma_read_ctrl_data_index, dma_read_ctrl_data_length;
  logic [2:0] dma_read_ctrl_data_size;
  logic dma_read_chnl_valid = 0, dma_read_chnl_ready;
  logic [63:0] dma_read_chnl_data = 0;
  logic dma_write_ctrl_valid, dma_write_ctrl_ready = 0;
  logic [31:0] dma_write_ctrl_data_index, dma_write_ctrl_data_length;
  logic [2:0] dma_write_ctrl_data_size;
  logic dma_write_chnl_valid, dma_write_chnl_ready = 0;
  logic [63:0] dma_write_chnl_data;
  logic acc_done;
  logic [31:0] debug;
  always #5 clk = ~clk;
  generic_tb_rtl_chunked_dma dut (
    .clk(clk), .rst(rst),
    .conf_info_reg0(conf_info_reg0), .conf_info_generic_tb_n(conf_info_generic_tb_n),
    .conf_info_reg2(conf_info_reg2), .conf_done(conf_done),
    .dma_read_ctrl_valid(dma_read_ctrl_valid), .dma_read_ctrl_ready(dma_read_ctrl_ready),
    .dma_read_ctrl_data_index(dma_read_ctrl_data_index),
    .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
    .dma_read_ctrl_data_size(dma_read_ctrl_data_size),
    .dma_read_chnl_valid(dma_read_chnl_valid), .dma_read_chnl_ready(dma_read_chnl_ready),
    .dma_read_chnl_data(dma_read_chnl_data),
    .dma_write_ctrl_valid(dma_write_ctrl_valid), .dma_write_ctrl_ready(dma_write_ctrl_ready),
    .dma_write_ctrl_data_index(dma_write_ctrl_data_index),
    .dma_write_ctrl_data_length(dma_write_ctrl_data_length),
    .dma_write_ctrl_data_size(dma_write_ctrl_data_size),
    .dma_write_chnl_valid(dma_write_chnl_valid), .dma_write_chnl_ready(dma_write_chnl_ready),
    .dma_write_chnl_data(dma_write_chnl_data),
    .acc_done(acc_done), .debug(debug)
  );
  typedef struct { int idx; int len; } burst_t;
  int errors = 0, checks = 0, done_cnt = 0;
  bit bp = 0;
  logic [63:0] in_mem [256];
  burst_t exp_rd[$], exp_wr[$], rd_bursts[$];
  logic [63:0] exp_data[$];
  int exp_done[$];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] ref_xf(input int m, input logic [63:0] d, input logic [31:0] a);
    case (m)
      0: return d;
      1: return d + 64'd1;
      2: return ~d;
      default: return d + {32'd0, a};
    endcase
  endfunction
  // reference model: expected bursts, words and chunk count straight from the rules
  task automatic start(input int n, input int m, input logic [31:0] a);
    for (int b = 0; b < n; b += CH) begin
      int l;
      l = (n - b < CH) ? n - b : CH;
      exp_rd.push_back('{b, l});
      exp_wr.push_back('{n + b, l});
      for (int k = 0; k < l; k++) exp_data.push_back(ref_xf(m, in_mem[b + k], a));
    end
    exp_done.push_back((n + CH - 1) / CH);
    @(negedge clk);
    conf_info_reg0 = 32'(m);
    conf_info_generic_tb_n = 32'(n);
    conf_info_reg2 = a;
    conf_done = 1;
  endtask
  task automatic wait_done(input string name, output int lat);
    int c0;
    c0 = done_cnt;
    lat = 0;
    while (done_cnt == c0 && lat < 4000) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (done_cnt == c0) begin
      errors++;
      $display("FAIL %s: no acc_done within %0d cycles", name, lat);
    end
    repeat (4) @(negedge clk);
    conf_done = 0;
    repeat (2) @(negedge clk);
    check({name, "_rd_left"}, 64'(exp_rd.size()), 0);
    check({name, "_wr_left"}, 64'(exp_wr.size()), 0);
    check({name, "_data_left"}, 64'(exp_data.size()), 0);
  endtask
  // memory-slave DMA model and monitor; every handshake is decided at the negedge before it fires
  initial begin
    bit rd_fired, wr_hold;
    int rd_ptr, rd_left;
    logic [63:0] wr_prev;
    burst_t e, b;
    rd_fired = 0; wr_hold = 0; rd_ptr = 0; rd_left = 0; wr_prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_fired = 0;
        rd_left = 0;
        wr_hold = 0;
        rd_bursts.delete();
        dma_read_chnl_valid = 0;
      end else begin
        dma_read_ctrl_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        dma_write_ctrl_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        dma_write_chnl_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (dma_read_ctrl_valid && dma_write_ctrl_valid) check("ctrl_overlap", 1, 0);
        if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
          check("rd_size", 64'(dma_read_ctrl_data_size), 3);
          if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
          else begin
            e = exp_rd.pop_front();
            check("rd_index", 64'(dma_read_ctrl_data_index), 64'(e.idx));
            check("rd_length", 64'(dma_read_ctrl_data_length), 64'(e.len));
          end
          rd_bursts.push_back('{int'(dma_read_ctrl_data_index), int'(dma_read_ctrl_data_length)});
        end
        if (dma_write_ctrl_valid && dma_write_ctrl_ready) begin
          check("wr_size", 64'(dma_write_ctrl_data_size), 3);
          if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
          else begin
            e = exp_wr.pop_front();
            check("wr_index", 64'(dma_write_ctrl_data_index), 64'(e.idx));
            check("wr_length", 64'(dma_write_ctrl_data_length), 64'(e.len));
          end
        end
        if (rd_fired) begin
          rd_ptr++;
          rd_left--;
          dma_read_chnl_valid = 0;
        end
        if (rd_left == 0 && rd_bursts.size() != 0) begin
          b = rd_bursts.pop_front();
          rd_ptr = b.idx;
          rd_left = b.len;
        end
        if (!dma_read_chnl_valid && rd_left > 0 && (!bp || $urandom_range(0, 2) != 0)) begin
          dma_read_chnl_valid = 1;
          dma_read_chnl_data = in_mem[rd_ptr[7:0]];
        end
        rd_fired = dma_read_chnl_valid && dma_read_chnl_ready;
        if (wr_hold) begin
          check("wr_hold_valid", 64'(dma_write_chnl_valid), 1);
          check("wr_hold_data", dma_write_chnl_data, wr_prev);
        end
        if (dma_write_chnl_valid && dma_write_chnl_ready) begin
          if (exp_data.size() == 0) check("wr_data_unexpected", 1, 0);
          else check("wr_data", dma_write_chnl_data, exp_data.pop_front());
        end
        wr_hold = dma_write_chnl_valid && !dma_write_chnl_ready;
        wr_prev = dma_write_chnl_data;
        if (acc_done) begin
          done_cnt++;
          check("done_state", 64'(debug[3:0]), 6);
          if (exp_done.size() == 0) check("done_unexpected", 1, 0);
          else check("done_chunks", 64'(debug[31:16]), 64'(exp_done.pop_front()));
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, k;
    for (int i = 0; i < 256; i++) in_mem[i] = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    check("rst_rd_ctrl_valid", 64'(dma_read_ctrl_valid), 0);
    check("rst_wr_ctrl_valid", 64'(dma_write_ctrl_valid), 0);
    check("rst_rd_chnl_ready", 64'(dma_read_chnl_ready), 0);
    check("rst_wr_chnl_valid", 64'(dma_write_chnl_valid), 0);
    check("rst_acc_done", 64'(acc_done), 0);
    check("rst_debug", 64'(debug), 0);
    rst = 0;
    repeat (2) @(negedge clk);
    start(0, 0, 0);
    wait_done("n0", lat);
    check("n0_latency_le3", 64'(lat <= 3), 1);
    for (int i = 0; i < 16; i++) in_mem[i] = 64'(i);
    start(16, 0, 0);
    wait_done("n16_copy", lat);
    for (int i = 0; i < 256; i++) in_mem[i] = {$urandom, $urandom};
    start(37, 1, 0);
    wait_done("n37_inc", lat);
    bp = 1;
    start(37, 1, 0);
    repeat (20) @(negedge clk);
    conf_done = 0;
    conf_info_reg0 = 2;
    conf_info_generic_tb_n = 5;
    @(negedge clk);
    conf_done = 1;
    wait_done("n37_bp", lat);
    start(40, 3, $urandom);
    wait_done("n40_add_bp", lat);
    bp = 0;
    in_mem[0] = 64'hFFFF_FFFF_FFFF_FFFE;
    start(1, 3, 5);
    wait_done("add_wrap", lat);
    in_mem[0] = 64'd0;
    start(1, 2, 0);
    wait_done("invert_zero", lat);
    start(37, 1, 0);
    k = 0;
    while (!(debug[3:0] == 4'd3 && debug[31:16] == 16'd1) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("reach_rd_data_chunk2", 64'(k < 2000), 1);
    rst = 1;
    @(negedge clk);
    check("abort_rd_ctrl_valid", 64'(dma_read_ctrl_valid), 0);
    check("abort_rd_chnl_ready", 64'(dma_read_chnl_ready), 0);
    check("abort_wr_ctrl_valid", 64'(dma_write_ctrl_valid), 0);
    check("abort_wr_chnl_valid", 64'(dma_write_chnl_valid), 0);
    check("abort_acc_done", 64'(acc_done), 0);
    check("abort_debug", 64'(debug), 0);
    exp_rd.delete();
    exp_wr.delete();
    exp_data.delete();
    exp_done.delete();
    conf_done = 0;
    @(negedge clk);
    rst = 0;
    repeat (6) @(negedge clk);
    bp = 1;
    start(37, 1, 0);
    wait_done("after_abort", lat);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
